// File: rtl/jbi_ncio_mrqq_pkg.sv
// Shared MRQQ sizing constants for the NCIO mondo/request queue.
package jbi_ncio_mrqq_pkg;

    localparam int JBI_MRQQ_ADDR_WIDTH = 4;
    localparam int JBI_MRQQ_AFULL_LVL  = 13;

endpackage

// File: rtl/jbi_ncio_mrqq_ptr.sv
// Wrapping array pointer: increments on enable, clears on synchronous reset.
module jbi_ncio_mrqq_ptr
    import jbi_ncio_mrqq_pkg::*;
#(
    parameter int W = JBI_MRQQ_ADDR_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-1:0] o_ptr
);

    logic [W-1:0] r_ptr;

    // Pointer register with natural power-of-two wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= {W{1'b0}};
        end else if (i_inc) begin
            r_ptr <= r_ptr + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/jbi_ncio_mrqq_ctl.sv
// MRQQ controller: turns enqueue strobes and a valid/ready dequeue into array
// enables/addresses, tracking occupancy around the array's registered read.
module jbi_ncio_mrqq_ctl
    import jbi_ncio_mrqq_pkg::*;
#(
    parameter int ADDR_WIDTH = JBI_MRQQ_ADDR_WIDTH,
    parameter int AFULL_LVL  = JBI_MRQQ_AFULL_LVL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mrqq_enq,
    input  logic                  mrqq_deq_rdy,
    output logic                  mrqq_wr_en,
    output logic [ADDR_WIDTH-1:0] mrqq_waddr,
    output logic                  mrqq_rd_en,
    output logic [ADDR_WIDTH-1:0] mrqq_raddr,
    output logic                  mrqq_deq_vld,
    output logic                  mrqq_full,
    output logic                  mrqq_afull,
    output logic [ADDR_WIDTH:0]   mrqq_cnt,
    output logic                  mrqq_ovf_err
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH     = CW'(1) << ADDR_WIDTH;
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);

    logic [CW-1:0] r_cnt;
    logic          r_vld;
    logic          r_full;
    logic          r_afull;
    logic          r_ovf;
    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_out_free;
    logic [CW-1:0] w_cnt_nxt;

    // The output register is free when empty or being consumed this cycle;
    // the count only covers entries not yet moved into it.
    assign w_out_free = ~r_vld | mrqq_deq_rdy;
    assign w_wr_en    = mrqq_enq & ~r_full;
    assign w_rd_en    = (r_cnt != {CW{1'b0}}) & w_out_free;
    assign w_cnt_nxt  = r_cnt + CW'(w_wr_en) - CW'(w_rd_en);

    // Occupancy, flow-control flags, head-valid and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= {CW{1'b0}};
            r_vld   <= 1'b0;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == DEPTH);
            r_afull <= (w_cnt_nxt >= AFULL_CNT);
            r_vld   <= w_out_free ? w_rd_en : 1'b1;
            r_ovf   <= r_ovf | (mrqq_enq & r_full);
        end
    end

    jbi_ncio_mrqq_ptr #(.W(ADDR_WIDTH)) u_wptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_wr_en),
        .o_ptr (mrqq_waddr)
    );

    jbi_ncio_mrqq_ptr #(.W(ADDR_WIDTH)) u_rptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_rd_en),
        .o_ptr (mrqq_raddr)
    );

    assign mrqq_wr_en   = w_wr_en;
    assign mrqq_rd_en   = w_rd_en;
    assign mrqq_deq_vld = r_vld;
    assign mrqq_full    = r_full;
    assign mrqq_afull   = r_afull;
    assign mrqq_cnt     = r_cnt;
    assign mrqq_ovf_err = r_ovf;

endmodule
